// File: rtl/spiflash_target.sv
// SPI flash target: oversamples the SPI pins on clk and serves power, WEL,
// status, JEDEC ID, single read, page program and quad/XIP read from a byte RAM.
module spiflash_target #(
  parameter int          ADDR_W   = 24,
  parameter int          DUMMY    = 8,
  parameter logic [23:0] JEDEC_ID = 24'hEF4018,
  parameter int          QUAD_EN  = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              spi_csb,
  input  logic              spi_sck,
  input  logic [3:0]        io_di,
  output logic [3:0]        io_do,
  output logic [3:0]        io_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  output logic              cmd_err,
  output logic [3:0]        dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_ADDR, S_MODE, S_DUMMY, S_RDATA, S_WDATA, S_REG, S_IGNORE
  } state_t;

  state_t      state;
  logic [1:0]  csb_sync, sck_sync;
  logic [3:0]  io_m, io_s;
  logic        csb_q, sck_q;
  logic        csb_s, sck_rise, sck_fall, csb_rise;
  logic [6:0]  sh;
  logic [2:0]  in_cnt, out_cnt;
  logic        quad, re_q, powered_up, wel, xip;
  logic [7:0]  op, out_sr, rd_buf, in_byte, src_byte, cur_byte;
  logic [1:0]  addr_cnt, reg_idx;
  logic [15:0] addr_sh;
  logic [23:0] full_addr;
  logic [3:0]  dcnt;
  logic        byte_done;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      csb_sync <= 2'b11;
      sck_sync <= 2'b00;
      io_m     <= 4'h0;
      io_s     <= 4'h0;
      csb_q    <= 1'b1;
      sck_q    <= 1'b0;
    end else begin
      csb_sync <= {csb_sync[0], spi_csb};
      sck_sync <= {sck_sync[0], spi_sck};
      io_m     <= io_di;
      io_s     <= io_m;
      csb_q    <= csb_sync[1];
      sck_q    <= sck_sync[1];
    end
  end

  assign csb_s     = csb_sync[1];
  assign sck_rise  = sck_sync[1] & ~sck_q;
  assign sck_fall  = ~sck_sync[1] & sck_q;
  assign csb_rise  = csb_s & ~csb_q;
  assign in_byte   = quad ? {sh[3:0], io_s} : {sh, io_s[0]};
  assign byte_done = sck_rise & (quad ? in_cnt[0] : (in_cnt == 3'd7));
  assign full_addr = {addr_sh, in_byte};
  assign dbg_state = state;

  // Byte to start shifting out at the next first-bit fall.
  always_comb begin
    src_byte = 8'h00;
    if (state == S_RDATA) src_byte = rd_buf;
    else if (op == 8'h05) src_byte = {6'b0, wel, 1'b0};
    else begin
      case (reg_idx)
        2'd0:    src_byte = JEDEC_ID[23:16];
        2'd1:    src_byte = JEDEC_ID[15:8];
        2'd2:    src_byte = JEDEC_ID[7:0];
        default: src_byte = 8'h00;
      endcase
    end
    cur_byte = (out_cnt == 3'd0) ? src_byte : out_sr;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;  io_do <= 4'h0;  io_oe <= 4'h0;
      mem_addr <= '0;   mem_re <= 1'b0; mem_we <= 1'b0; mem_wdata <= 8'h00;
      cmd_err <= 1'b0;  sh <= 7'h0;     in_cnt <= 3'd0; out_cnt <= 3'd0;
      quad <= 1'b0;     re_q <= 1'b0;   powered_up <= 1'b0;
      wel <= 1'b0;      xip <= 1'b0;    op <= 8'h00;    out_sr <= 8'h00;
      rd_buf <= 8'h00;  addr_cnt <= 2'd0; reg_idx <= 2'd0;
      addr_sh <= 16'h0; dcnt <= 4'd0;
    end else begin
      mem_re  <= 1'b0;
      mem_we  <= 1'b0;
      cmd_err <= 1'b0;
      re_q    <= mem_re;
      if (re_q) rd_buf <= mem_rdata;
      // Page program wraps inside the 256-byte page.
      if (mem_we) mem_addr[7:0] <= mem_addr[7:0] + 8'd1;
      if (sck_rise) begin
        sh     <= in_byte[6:0];
        in_cnt <= in_cnt + 3'd1;
      end
      if (csb_rise) begin
        state <= S_IDLE;
        io_oe <= 4'h0;
        if (op == 8'h02 && (state == S_ADDR || state == S_WDATA)) wel <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (!csb_s) begin
            in_cnt <= 3'd0; out_cnt <= 3'd0; addr_cnt <= 2'd0;
            reg_idx <= 2'd0; dcnt <= 4'd0;
            if (xip) begin
              state <= S_ADDR; quad <= 1'b1; op <= 8'hEB;
            end else begin
              state <= S_CMD;  quad <= 1'b0;
            end
          end
          S_CMD: if (byte_done) begin
            op    <= in_byte;
            state <= S_IGNORE;
            if (powered_up || in_byte == 8'hAB) begin
              case (in_byte)
                8'hAB: powered_up <= 1'b1;
                8'hB9: powered_up <= 1'b0;
                8'hFF: xip <= 1'b0;
                8'h06: wel <= 1'b1;
                8'h04: wel <= 1'b0;
                8'h05, 8'h9F: state <= S_REG;
                8'h03, 8'h02: state <= S_ADDR;
                8'hEB: begin
                  if (QUAD_EN != 0) begin
                    state <= S_ADDR; quad <= 1'b1;
                  end else cmd_err <= 1'b1;
                end
                default: cmd_err <= 1'b1;
              endcase
            end
          end
          S_ADDR: if (byte_done) begin
            addr_sh  <= full_addr[15:0];
            addr_cnt <= addr_cnt + 2'd1;
            if (addr_cnt == 2'd2) begin
              mem_addr <= full_addr[ADDR_W-1:0];
              if (op == 8'h02) state <= S_WDATA;
              else begin
                mem_re <= 1'b1;
                state  <= (op == 8'hEB) ? S_MODE : S_RDATA;
              end
            end
          end
          S_MODE: if (byte_done) begin
            xip   <= (in_byte == 8'hA5);
            dcnt  <= 4'd0;
            state <= (DUMMY == 0) ? S_RDATA : S_DUMMY;
          end
          S_DUMMY: if (sck_rise) begin
            dcnt <= dcnt + 4'd1;
            if (dcnt == 4'(DUMMY - 1)) state <= S_RDATA;
          end
          S_RDATA, S_REG: if (sck_fall) begin
            io_do   <= quad ? cur_byte[7:4] : {2'b00, cur_byte[7], 1'b0};
            io_oe   <= quad ? 4'hF : 4'b0010;
            out_sr  <= quad ? {cur_byte[3:0], 4'h0} : {cur_byte[6:0], 1'b0};
            out_cnt <= quad ? {2'b00, ~out_cnt[0]} : out_cnt + 3'd1;
            // First bit of a byte: prefetch the next one so SCK never stalls.
            if (out_cnt == 3'd0) begin
              if (state == S_RDATA) begin
                mem_re   <= 1'b1;
                mem_addr <= mem_addr + ADDR_W'(1);
              end else if (reg_idx != 2'd3) reg_idx <= reg_idx + 2'd1;
            end
          end
          S_WDATA: if (byte_done && wel) begin
            mem_we    <= 1'b1;
            mem_wdata <= in_byte;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/spiflash_target.md
SPIFLASH_TARGET -- requirements
Module: spiflash_target

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter ADDR_W, default 24: memory address bits used; incoming 24-bit addresses are truncated to the low ADDR_W bits.
REQ-002 The block SHALL have parameter DUMMY, default 8: dummy SCK cycles for EB (quad read), 0..15.
REQ-003 The block SHALL have parameter JEDEC_ID, default 24'hEF4018: bytes returned by 9F, MSB first.
REQ-004 The block SHALL have parameter QUAD_EN, default 1: 0 makes EB unsupported.

Ports (name, direction, width, meaning):
REQ-005 The block SHALL have port clk, input, 1: system clock, single clock domain.
REQ-006 The block SHALL have port resetn, input, 1: asynchronous active-low reset.
REQ-007 The block SHALL have port spi_csb, input, 1: chip select, active low, asynchronous to clk.
REQ-008 The block SHALL have port spi_sck, input, 1: SPI clock, mode 0, asynchronous to clk.
REQ-009 The block SHALL have port io_di, input, 4: pad inputs io3..io0.
REQ-010 The block SHALL have ports io_do and io_oe, outputs, 4 each: pad data and per-lane output enables.
REQ-011 The block SHALL have ports mem_addr (output, ADDR_W), mem_re (output, 1), mem_rdata (input, 8), mem_we (output, 1), mem_wdata (output, 8): synchronous byte RAM port; mem_rdata is valid 1 clk after mem_re.
REQ-012 The block SHALL have port cmd_err, output, 1: 1-clk pulse when an unsupported opcode is received.

Function
REQ-013 spi_csb, spi_sck and io_di SHALL pass through a 2-flop synchroniser; SCK edges SHALL be detected on synchronised samples; f_clk >= 8*f_sck is required.
REQ-014 The block SHALL sample lanes on the detected SCK rise and SHALL update io_do/io_oe within 2 clk of the detected SCK fall.
REQ-015 The FSM SHALL have states IDLE, CMD, ADDR, MODE, DUMMY, RDATA, WDATA, REG, IGNORE; a csb rise SHALL force IDLE from any state and clear io_oe.
REQ-016 CMD SHALL shift 8 bits on io0, MSB first; a byte completes on the 8th rise.
REQ-017 Opcodes: AB power-up; B9 power-down; FF clears XIP; 06 sets WEL; 04 clears WEL; 05 returns status {6'b0,WEL,1'b0} repeatedly; 9F returns JEDEC_ID then 8'h00; 03 single read; 02 page program; EB quad read.
REQ-018 While powered down, every opcode except AB SHALL go to IGNORE with no outputs driven and no cmd_err.
REQ-019 An unknown opcode, or EB with QUAD_EN=0, SHALL pulse cmd_err and go to IGNORE.
REQ-020 The 03 command SHALL take a 3-byte address on io0, then output bytes on io1 (io_oe=4'b0010) with the address incrementing and wrapping at 2^ADDR_W.
REQ-021 The EB command SHALL take the address and mode byte on 4 lanes, then DUMMY cycles with io_oe=0, then data on 4 lanes (io_oe=4'hF), high nibble first.
REQ-022 An EB mode byte of 8'hA5 SHALL set XIP, and any other mode byte SHALL clear it; with XIP set, the next transaction SHALL skip CMD and enter ADDR as EB.
REQ-023 Reads SHALL issue mem_re for the first byte at address completion and prefetch byte n+1 at the first output bit of byte n, so no SCK stall occurs.
REQ-024 The 02 command with WEL=1 SHALL write each data byte with a 1-clk mem_we at the completed byte, incrementing only addr[7:0] (256-byte page wrap).
REQ-025 The 02 command with WEL=0 SHALL accept and discard data with no mem_we.
REQ-026 WEL SHALL clear at the csb rise ending any 02 transaction.
REQ-027 A partial byte at a csb rise SHALL be discarded: no mem_we and no state change, except that WEL clears after 02.
REQ-028 mem_we and mem_re SHALL never be asserted in the same clk.

Reset
REQ-029 While resetn=0 the block SHALL hold state IDLE, io_oe=0, io_do=0, mem_re=0, mem_we=0, cmd_err=0, mem_addr=0, and SHALL clear powered_up, WEL and XIP.
REQ-030 Reset asserted mid-transaction SHALL abort the transaction immediately, and the block SHALL require AB before any further command.

Verification
REQ-031 AB; then 03 000010 with mem[0x10..0x12]=11,22,33 -> io1 shifts 11,22,33 and io_oe=0010.
REQ-032 Reset, then 9F -> no output (powered down); then AB, 9F -> EF,40,18,00.
REQ-033 AB, 06, then 02 0000FE with data AA,BB,CC -> writes FE=AA, FF=BB, 00=CC; then 05 -> 00 (WEL cleared).
REQ-034 AB, EB 000100 with mode A5 and DUMMY=8 -> 4-lane data from 0x100; the next csb with an address only -> data from the new address; FF -> XIP cleared.
REQ-035 AB, opcode 5A -> one cmd_err pulse and io_oe stays 0; 02 without 06 -> no mem_we.
REQ-036 resetn low during 03 data -> io_oe=0 within 1 clk; after release, 03 is ignored until AB.
